// File: rtl/arith_sequencer_pkg.sv
// Shared op codes and FSM state encodings for the calculator arithmetic sequencer.
// The op codes match the display result mux select.
package arith_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(op_t op_code);
    return (op_code == OP_MUL) || (op_code == OP_DIV);
  endfunction

endpackage

// File: rtl/arith_iter_step.sv
// One combinational iteration of the multi-cycle datapath: a shift-add partial
// product for MUL, or one MSB-first restoring-division bit for DIV.
module arith_iter_step
  import arith_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = 2,
  localparam int RW   = 2 * WIDTH
) (
  input  logic              is_div,
  input  logic [CW-1:0]     cnt,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [RW-1:0]     acc_in,
  input  logic [WIDTH-1:0]  rem_in,
  output logic [RW-1:0]     acc_out,
  output logic [WIDTH-1:0]  rem_out
);

  logic [CW-1:0]  bit_idx;
  logic [WIDTH:0] rem_sh;

  always_comb begin
    bit_idx = CW'(WIDTH - 1) - cnt;
    rem_sh  = {rem_in, a[bit_idx]};
    acc_out = acc_in;
    rem_out = rem_in;
    if (is_div) begin
      // Partial remainder stays below b, so the difference always fits WIDTH bits.
      if (rem_sh >= {1'b0, b}) begin
        rem_out = rem_sh[WIDTH-1:0] - b;
        acc_out = acc_in | (RW'(1) << bit_idx);
      end else begin
        rem_out = rem_sh[WIDTH-1:0];
      end
    end else if (a[cnt]) begin
      acc_out = acc_in + (RW'(b) << cnt);
    end
  end

endmodule

// File: rtl/arith_sequencer.sv
// Multi-cycle controller for the calculator datapath: start/busy/done handshake,
// single-step add/sub and iterative shift-add multiply / restoring divide.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; operands latched on accept
//   ST_EXEC | add/sub takes one edge, mul/div one iteration per edge
//   ST_DONE | outputs valid, done pulse high for this single cycle
module arith_sequencer
  import arith_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int RW   = 2 * WIDTH,
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [RW-1:0]     result,
  output logic              carry,
  output logic [WIDTH-1:0]  remainder,
  output logic              err_div0
);

  state_t           state, state_nxt;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    acc, step_acc;
  logic [WIDTH-1:0] rem, step_rem;
  logic [WIDTH:0]   addsub;
  logic             last_step;
  logic             div0;

  assign div0      = (op_t'(op) == OP_DIV) && (b == '0);
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // Subtract as a + ~b + 1 so the top bit reads as "no borrow".
  assign addsub = (op_q == OP_SUB) ? ({1'b0, a_q} + {1'b0, ~b_q} + (WIDTH + 1)'(1))
                                   : ({1'b0, a_q} + {1'b0, b_q});

  arith_iter_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .is_div  (op_q == OP_DIV),
    .cnt     (cnt),
    .a       (a_q),
    .b       (b_q),
    .acc_in  (acc),
    .rem_in  (rem),
    .acc_out (step_acc),
    .rem_out (step_rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = div0 ? ST_DONE : ST_EXEC;
      ST_EXEC: if (!is_iterative(op_q) || last_step) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      acc       <= '0;
      rem       <= '0;
      result    <= '0;
      carry     <= 1'b0;
      remainder <= '0;
      err_div0  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op_t'(op);
            a_q  <= a;
            b_q  <= b;
            cnt  <= '0;
            acc  <= '0;
            rem  <= '0;
            if (div0) begin
              result    <= '0;
              carry     <= 1'b0;
              remainder <= a;
              err_div0  <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (!is_iterative(op_q)) begin
            result    <= {{(RW - WIDTH){1'b0}}, addsub[WIDTH-1:0]};
            carry     <= addsub[WIDTH];
            remainder <= '0;
            err_div0  <= 1'b0;
          end else begin
            acc <= step_acc;
            rem <= step_rem;
            cnt <= cnt + CW'(1);
            if (last_step) begin
              result    <= (op_q == OP_MUL) ? step_acc
                                            : {{(RW - WIDTH){1'b0}}, step_acc[WIDTH-1:0]};
              carry     <= 1'b0;
              remainder <= (op_q == OP_DIV) ? step_rem : '0;
              err_div0  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_sequencer.sv
// Bench for arith_sequencer: arithmetic reference model checked every cycle,
// plus directed literal cases for latency, busy/done shape, abort and back-to-back.
module tb_arith_sequencer;

  localparam int WIDTH = 4;
  localparam int RW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op = 2'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, carry, err_div0;
  logic [RW-1:0]    result;
  logic [WIDTH-1:0] remainder;

  int n_checks = 0;
  int n_pass   = 0;

  arith_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry     (carry),
    .remainder (remainder),
    .err_div0  (err_div0)
  );

  always #5 clk = ~clk;

  // Reference: outputs straight from integer arithmetic; m_left = cycles of busy still to go.
  int            m_left = 0;
  logic [RW-1:0] m_res = '0, p_res;
  logic          m_car = 1'b0, p_car;
  logic [3:0]    m_rem = '0, p_rem;
  logic          m_err = 1'b0, p_err;

  task automatic compute(input logic [1:0] o, input int x, input int y,
                         output logic [RW-1:0] res, output logic car,
                         output logic [3:0] rm, output logic er, output int cyc);
    res = '0; car = 1'b0; rm = '0; er = 1'b0; cyc = 2;
    case (o)
      2'd0: begin res = RW'((x + y) % 16); car = ((x + y) >= 16); end
      2'd1: begin res = RW'((x - y + 16) % 16); car = (x >= y); end
      2'd2: begin res = RW'(x * y); cyc = WIDTH + 1; end
      default: begin
        if (y == 0) begin rm = 4'(x); er = 1'b1; cyc = 1; end
        else begin res = RW'(x / y); rm = 4'(x % y); cyc = WIDTH + 1; end
      end
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_res = '0; m_car = 1'b0; m_rem = '0; m_err = 1'b0;
    end else begin
      if (m_left == 0) begin
        if (start) compute(op, int'(a), int'(b), p_res, p_car, p_rem, p_err, m_left);
      end else begin
        m_left--;
      end
      if (m_left == 1) begin
        m_res = p_res; m_car = p_car; m_rem = p_rem; m_err = p_err;
      end
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (busy === (m_left > 0) && done === (m_left == 1) && result === m_res &&
        carry === m_car && remainder === m_rem && err_div0 === m_err)
      n_pass++;
    else
      $display("FAIL model_cmp t=%0t got busy=%b done=%b result=%h carry=%b rem=%h err=%b exp busy=%b done=%b result=%h carry=%b rem=%h err=%b",
               $time, busy, done, result, carry, remainder, err_div0,
               (m_left > 0), (m_left == 1), m_res, m_car, m_rem, m_err);
  end

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [3:0] x,
                        input logic [3:0] y, input int e_res, input int e_car,
                        input int e_rem, input int e_err, input int e_lat);
    int lat, nb;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
    lat = 0;
    nb = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      nb += busy ? 1 : 0;
    end
    check({nm, "_latency"}, lat, e_lat);
    check({nm, "_result"}, int'(result), e_res);
    check({nm, "_carry"}, int'(carry), e_car);
    check({nm, "_remainder"}, int'(remainder), e_rem);
    check({nm, "_err_div0"}, int'(err_div0), e_err);
    check({nm, "_busy_cycles"}, nb, e_lat + 1);
    @(negedge clk);
    check({nm, "_done_pulse_end"}, int'({busy, done}), 0);
  endtask

  initial begin
    int cyc, ndone, last_done;

    repeat (2) @(negedge clk);
    check("reset_outputs", int'({busy, done, result, carry, remainder, err_div0}), 0);
    reset = 1'b0;

    run_op("add_9_8",   2'd0,  9,  8, 8'h01, 1, 0, 0, 1);
    run_op("sub_3_5",   2'd1,  3,  5, 8'h0E, 0, 0, 0, 1);
    run_op("sub_5_3",   2'd1,  5,  3, 8'h02, 1, 0, 0, 1);
    run_op("mul_15_15", 2'd2, 15, 15, 8'hE1, 0, 0, 0, 4);
    run_op("mul_0_9",   2'd2,  0,  9, 8'h00, 0, 0, 0, 4);
    run_op("div_13_4",  2'd3, 13,  4, 8'h03, 0, 1, 0, 4);
    run_op("div_7_0",   2'd3,  7,  0, 8'h00, 0, 7, 1, 0);

    // Start with a different op while a MUL is executing must be ignored.
    @(negedge clk); start = 1'b1; op = 2'd2; a = 4'd6; b = 4'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; op = 2'd0; a = 4'd1; b = 4'd1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    check("mul_ignore_start_done_seen", int'(done), 1);
    check("mul_ignore_start_result", int'(result), 8'h2A);
    @(negedge clk);

    // Abort a MUL in its second EXEC cycle.
    @(negedge clk); start = 1'b1; op = 2'd2; a = 4'd9; b = 4'd9;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    #1 check("abort_outputs_zero", int'({busy, done, result, carry, remainder, err_div0}), 0);
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    repeat (8) begin @(negedge clk); ndone += done ? 1 : 0; end
    check("abort_no_done", ndone, 0);

    // Start held high: new ADD every third cycle.
    @(negedge clk); start = 1'b1; op = 2'd0; a = 4'd1; b = 4'd1;
    ndone = 0; last_done = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        check("held_start_result", int'(result), 2);
        if (last_done >= 0) check("held_start_spacing", i - last_done, 3);
        last_done = i;
        ndone++;
      end
    end
    start = 1'b0;
    check("held_start_done_count", ndone, 4);
    repeat (3) @(negedge clk);

    // Random sweep, checked by the reference model each cycle.
    repeat (400) begin
      @(negedge clk);
      start = ($urandom % 3) != 0;
      op    = 2'($urandom);
      a     = 4'($urandom);
      b     = ($urandom % 5 == 0) ? 4'd0 : 4'($urandom);
    end
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
